// File: rtl/pipe_stage_reg_if.sv
// Valid/ready payload channel between pipeline stages.
// The master drives valid and data. The slave drives ready.
interface pipe_stage_reg_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a registered-ready two-entry skid buffer, flush and bubble (NOP) output.
// Latency is one cycle. in_ready comes only from state, so one transfer per cycle is sustained with no comb path from out_ready.
module pipe_stage_reg #(
  parameter int          WIDTH     = 32,
  parameter logic [31:0] NOP_VALUE = 32'h00000013,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  pipe_stage_reg_if.slave  up,
  pipe_stage_reg_if.master dn,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [WIDTH-1:0] NOP     = WIDTH'(NOP_VALUE);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // State bits are {main_valid, skid_valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    TWO   = 2'b11
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;
  logic             main_valid;
  logic             skid_valid;
  logic             acc;
  logic             pop;
  logic             load_main;
  logic             main_from_skid;
  logic             load_skid;

  assign main_valid = state[1];
  assign skid_valid = state[0];
  assign acc        = up.valid & ~skid_valid & ~flush;
  assign pop        = main_valid & dn.ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (acc) begin
          state_nxt = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (acc && pop) begin
          load_main = 1'b1;
        end else if (acc) begin
          state_nxt = TWO;
          load_skid = 1'b1;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_nxt      = ONE;
          load_main      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush wins over every transition; a pop in this cycle has already been delivered.
    if (flush) begin
      state_nxt = EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
    end
  end

  always_comb begin
    up.ready  = ~skid_valid;
    dn.valid  = main_valid;
    dn.data   = main_valid ? main_data : NOP;
    occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data <= NOP;
      skid_data <= NOP;
    end else begin
      if (load_main) begin
        main_data <= main_from_skid ? skid_data : up.data;
      end
      if (load_skid) begin
        skid_data <= up.data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (main_valid && !dn.ready && stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized and directed bench for pipe_stage_reg. It checks the DUT against a queue-based model of held entries.
module tb_pipe_stage_reg;

  localparam logic [31:0] NOP  = 32'h00000013;
  localparam int          MAXS = 65535;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b1;
  logic        flush   = 1'b0;
  logic        s_flush = 1'b0;
  logic [1:0]  occ;
  logic [1:0]  s_occ;
  logic [15:0] stall;
  logic [3:0]  s_stall;

  int checks = 0;
  int errors = 0;

  logic [31:0] mq[$];
  int          m_stall = 0;

  pipe_stage_reg_if #(.WIDTH(32)) up_if();
  pipe_stage_reg_if #(.WIDTH(32)) dn_if();
  pipe_stage_reg_if #(.WIDTH(32)) s_up();
  pipe_stage_reg_if #(.WIDTH(32)) s_dn();

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .up(up_if), .dn(dn_if),
    .occupancy(occ), .stall_cnt(stall)
  );

  pipe_stage_reg #(.WIDTH(32), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(s_flush), .up(s_up), .dn(s_dn),
    .occupancy(s_occ), .stall_cnt(s_stall)
  );

  // Advance one clock. The model queue holds at most two entries and is updated from the pre-edge inputs.
  task automatic tick();
    int          sz;
    bit          m_acc;
    bit          m_pop;
    logic [31:0] din;
    sz    = mq.size();
    m_acc = up_if.valid && (sz < 2) && !flush;
    m_pop = (sz > 0) && dn_if.ready;
    din   = up_if.data;
    if (sz > 0 && !dn_if.ready && m_stall < MAXS) m_stall++;
    @(posedge clk);
    #1;
    if (m_pop) void'(mq.pop_front());
    if (flush) mq.delete();
    else if (m_acc) mq.push_back(din);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++; if (dn_if.valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", dn_if.valid); end
    checks++; if (dn_if.data !== NOP) begin errors++; $display("FAIL reset_out_data got %h want %h", dn_if.data, NOP); end
    checks++; if (up_if.ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", up_if.ready); end
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL reset_occupancy got %0d want 0", occ); end
    checks++; if (stall !== 16'd0) begin errors++; $display("FAIL reset_stall got %0d want 0", stall); end
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic test_stream();
    dn_if.ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      up_if.valid = 1'b1;
      up_if.data  = 32'(k);
      tick();
      checks++; if (dn_if.data !== 32'(k) || dn_if.valid !== 1'b1) begin errors++; $display("FAIL stream_data got %h/%0b want %h/1", dn_if.data, dn_if.valid, k); end
      checks++; if (occ !== 2'd1) begin errors++; $display("FAIL stream_occ got %0d want 1", occ); end
      checks++; if (stall !== 16'd0) begin errors++; $display("FAIL stream_stall got %0d want 0", stall); end
    end
    up_if.valid = 1'b0;
    tick();
    checks++; if (dn_if.valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %0b want 0", dn_if.valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] seen[$];
    up_if.valid = 1'b1; up_if.data = 32'd10; tick();
    checks++; if (dn_if.data !== 32'd10) begin errors++; $display("FAIL bp_first got %h want 10", dn_if.data); end
    dn_if.ready = 1'b0; up_if.data = 32'd11; tick();
    checks++; if (occ !== 2'd2 || up_if.ready !== 1'b0) begin errors++; $display("FAIL bp_skid got occ %0d rdy %0b want 2 0", occ, up_if.ready); end
    checks++; if (stall !== 16'd1) begin errors++; $display("FAIL bp_stall1 got %0d want 1", stall); end
    up_if.data = 32'd12; tick(); tick();
    checks++; if (occ !== 2'd2 || dn_if.data !== 32'd10) begin errors++; $display("FAIL bp_hold got occ %0d data %h want 2 10", occ, dn_if.data); end
    dn_if.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (dn_if.valid) seen.push_back(dn_if.data);
      if (i == 2) up_if.valid = 1'b0;
      tick();
    end
    checks++; if (seen.size() != 3 || seen[0] !== 32'd10 || seen[1] !== 32'd11 || seen[2] !== 32'd12) begin errors++; $display("FAIL bp_order got %0d items first %h want 10,11,12", seen.size(), seen[0]); end
    checks++; if (stall !== 16'd3) begin errors++; $display("FAIL bp_stall got %0d want 3", stall); end
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL bp_empty got %0d want 0", occ); end
  endtask

  task automatic test_flush_two();
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1; up_if.data = 32'h21; tick();
    up_if.data = 32'h22; tick();
    checks++; if (occ !== 2'd2) begin errors++; $display("FAIL flush_setup got occ %0d want 2", occ); end
    dn_if.ready = 1'b1; up_if.data = 32'h55; flush = 1'b1;
    checks++; if (dn_if.valid !== 1'b1 || dn_if.data !== 32'h21) begin errors++; $display("FAIL flush_deliver got %0b/%h want 1/21", dn_if.valid, dn_if.data); end
    tick();
    flush = 1'b0; up_if.valid = 1'b0;
    checks++; if (dn_if.valid !== 1'b0 || dn_if.data !== NOP) begin errors++; $display("FAIL flush_out got %0b/%h want 0/%h", dn_if.valid, dn_if.data, NOP); end
    checks++; if (up_if.ready !== 1'b1 || occ !== 2'd0) begin errors++; $display("FAIL flush_state got rdy %0b occ %0d want 1 0", up_if.ready, occ); end
    checks++; if (stall !== 16'(m_stall)) begin errors++; $display("FAIL flush_stall got %0d want %0d", stall, m_stall); end
    tick();
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL flush_no55 got occ %0d want 0", occ); end
  endtask

  task automatic test_bubble();
    int st;
    st = m_stall;
    up_if.valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (dn_if.valid !== 1'b0 || dn_if.data !== NOP) begin errors++; $display("FAIL bubble_out got %0b/%h want 0/%h", dn_if.valid, dn_if.data, NOP); end
      checks++; if (stall !== 16'(st)) begin errors++; $display("FAIL bubble_stall got %0d want %0d", stall, st); end
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_data;
    for (int i = 0; i < 400; i++) begin
      up_if.valid = ($urandom_range(0, 3) != 0);
      up_if.data  = $urandom;
      dn_if.ready = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 15) == 0);
      tick();
      exp_data = (mq.size() > 0) ? mq[0] : NOP;
      checks++; if (dn_if.valid !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_valid cyc %0d got %0b want %0b", i, dn_if.valid, mq.size() > 0); end
      checks++; if (dn_if.data !== exp_data) begin errors++; $display("FAIL rnd_data cyc %0d got %h want %h", i, dn_if.data, exp_data); end
      checks++; if (up_if.ready !== (mq.size() < 2)) begin errors++; $display("FAIL rnd_ready cyc %0d got %0b want %0b", i, up_if.ready, mq.size() < 2); end
      checks++; if (occ !== 2'(mq.size())) begin errors++; $display("FAIL rnd_occ cyc %0d got %0d want %0d", i, occ, mq.size()); end
      checks++; if (stall !== 16'(m_stall)) begin errors++; $display("FAIL rnd_stall cyc %0d got %0d want %0d", i, stall, m_stall); end
    end
    up_if.valid = 1'b0; dn_if.ready = 1'b1; flush = 1'b0;
  endtask

  task automatic test_saturation();
    s_dn.ready = 1'b0;
    s_up.valid = 1'b1; s_up.data = 32'hAA; tick();
    s_up.valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++; if (s_stall !== 4'((i < 15) ? i : 15)) begin errors++; $display("FAIL sat_count step %0d got %0d want %0d", i, s_stall, (i < 15) ? i : 15); end
    end
    s_flush = 1'b1; tick(); s_flush = 1'b0;
    checks++; if (s_stall !== 4'd15 || s_dn.valid !== 1'b0) begin errors++; $display("FAIL sat_flush got %0d/%0b want 15/0", s_stall, s_dn.valid); end
    #3 rst_n = 1'b0;
    mq.delete(); m_stall = 0;
    #1;
    checks++; if (s_stall !== 4'd0) begin errors++; $display("FAIL sat_reset got %0d want 0", s_stall); end
    #1 rst_n = 1'b1;
    s_dn.ready = 1'b1;
  endtask

  task automatic test_async_reset();
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1; up_if.data = 32'h31; tick();
    up_if.data = 32'h32; tick();
    up_if.valid = 1'b0;
    checks++; if (occ !== 2'd2) begin errors++; $display("FAIL ar_setup got occ %0d want 2", occ); end
    #3 rst_n = 1'b0;
    mq.delete(); m_stall = 0;
    #1;
    checks++; if (dn_if.valid !== 1'b0 || dn_if.data !== NOP) begin errors++; $display("FAIL ar_out got %0b/%h want 0/%h", dn_if.valid, dn_if.data, NOP); end
    checks++; if (up_if.ready !== 1'b1 || occ !== 2'd0 || stall !== 16'd0) begin errors++; $display("FAIL ar_state got rdy %0b occ %0d stall %0d want 1 0 0", up_if.ready, occ, stall); end
    #1 rst_n = 1'b1;
    dn_if.ready = 1'b1;
    for (int k = 7; k <= 8; k++) begin
      up_if.valid = 1'b1; up_if.data = 32'(k); tick();
      checks++; if (dn_if.valid !== 1'b1 || dn_if.data !== 32'(k)) begin errors++; $display("FAIL ar_stream got %0b/%h want 1/%h", dn_if.valid, dn_if.data, k); end
    end
    up_if.valid = 1'b0;
    tick();
  endtask

  initial begin
    up_if.valid = 1'b0; up_if.data = '0; dn_if.ready = 1'b1;
    s_up.valid  = 1'b0; s_up.data  = '0; s_dn.ready  = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_two();
    test_bubble();
    test_random();
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer, flush, and bubble insertion. It replaces the fixed per-stage latches between fetch/decode, decode/execute, execute/memory and memory/writeback: each boundary instantiates it with its own payload width. Stalls are carried by backpressure through `out_ready`/`in_ready` rather than by a write-enable. Full throughput of one transfer per cycle is sustained with a registered `in_ready`.

## Interface
Parameters:
- `WIDTH`, 32, payload width in bits; the stage's concatenated fields (PC, instr, control bits, rd, ...), minimum 1.
- `NOP_VALUE`, 32'h00000013, payload presented on `out_data` when no valid entry is held; zero-extended or truncated to `WIDTH`.
- `CNT_W`, 16, width of the stall counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous; drops all held entries and any input handshake in the same cycle.
- `in_valid`  in  1  upstream holds a payload.
- `in_ready`  out  1  stage can accept; registered.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  stage presents a payload.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  WIDTH  presented payload.
- `occupancy`  out  2  number of held entries, 0 to 2.
- `stall_cnt`  out  CNT_W  saturating count of cycles with `out_valid`=1 and `out_ready`=0.

## Operation
- Storage consists of a main entry (`main_valid`, `main_data`), which drives the outputs, and a skid entry (`skid_valid`, `skid_data`).
- `out_valid` = `main_valid`.
- `out_data` = `main_data` when `main_valid`=1, otherwise `NOP_VALUE`.
- `in_ready` = !`skid_valid`.
- `occupancy` = `main_valid` + `skid_valid`.
- Per-cycle events: `acc` = `in_valid` & `in_ready` & !`flush`; `pop` = `out_valid` & `out_ready`.
- States are encoded by the valid bits: EMPTY (0,0), ONE (1,0), TWO (1,1). The state (0,1) is illegal and never reached.
- EMPTY:
  - `acc` → ONE, `main_data`<=`in_data`.
  - Otherwise stay in EMPTY.
- ONE:
  - `acc`&`pop` → ONE, `main_data`<=`in_data`.
  - `acc`&!`pop` → TWO, `skid_data`<=`in_data`.
  - !`acc`&`pop` → EMPTY.
  - Neither → hold.
- TWO (`in_ready`=0, so no `acc`):
  - `pop` → ONE, `main_data`<=`skid_data`.
  - Otherwise hold.
- `flush`=1 → EMPTY next cycle, regardless of state, `pop`, or `in_valid`.
  - A downstream `pop` in the flush cycle still completes; downstream owns that payload.
  - An upstream payload offered in the flush cycle is discarded even though `in_ready` may read 1. Upstream treats it as flushed.
- Data registers load only on the transitions listed above; they otherwise hold their value. Payload is never reordered, duplicated or dropped except by `flush`.
- `stall_cnt` increments each cycle `out_valid`&!`out_ready`, saturates at 2^CNT_W−1, and is unaffected by `flush`. Only reset clears it.

## Timing
- Reset (`rst_n`=0, asynchronous, effective immediately, no clock required):
  - `main_valid`=`skid_valid`=0.
  - `main_data`=`skid_data`=`NOP_VALUE`.
  - `out_valid`=0, `out_data`=`NOP_VALUE`, `in_ready`=1, `occupancy`=0, `stall_cnt`=0.
- Reset deassertion is sampled synchronously. The first `acc` is possible on the first rising edge with `rst_n`=1.
- Reset mid-operation discards both entries at once. No partial transfer survives.
- Latency: `in_data` accepted at edge N appears on `out_data` after edge N (one cycle) when the stage was EMPTY, or ONE with a `pop` at edge N.
- Throughput: one transfer per cycle while `out_ready`=1, with `occupancy` steady at 1.
- `in_ready` depends only on registered state. There is no combinational path from `out_ready` to `in_ready`.
- `out_valid`/`out_data` are registered. There is no combinational path from `in_*`.
- On the first stall cycle in ONE, the stage still accepts one more entry (the skid). `in_ready` falls on the following cycle.
- Simultaneous `flush` and `pop` in TWO: the main entry is delivered, the skid entry is dropped, and the stage is EMPTY next cycle.

## Test plan
- Reset, then stream: hold `out_ready`=1 and drive `in_data`=1,2,3,4 on consecutive cycles with `in_valid`=1 → `out_data`=1,2,3,4 on consecutive cycles, one cycle behind; `occupancy`=1 throughout; `stall_cnt`=0.
- Backpressure: stream 10,11,12 with `out_ready`=0 from the cycle 10 appears:
  - 11 is taken into the skid; `in_ready`=0 the next cycle; 12 is held upstream; `occupancy`=2.
  - After `out_ready`=1, the output reads 10,11,12 in order with no loss.
  - `stall_cnt` equals the number of stalled cycles.
- Flush in TWO with `out_ready`=1 and `in_valid`=1 (payload 0x55):
  - The main entry is delivered.
  - The skid entry and 0x55 are dropped.
  - Next cycle: `out_valid`=0, `out_data`=0x00000013, `in_ready`=1.
- Bubble: EMPTY with `in_valid`=0 for 3 cycles → `out_valid`=0 and `out_data`=`NOP_VALUE` each cycle; `stall_cnt` unchanged.
- Saturation: with `CNT_W`=4, hold `out_valid`=1 and `out_ready`=0 for 20 cycles → `stall_cnt` stops at 15; a `flush` leaves it at 15; `rst_n`=0 clears it to 0 asynchronously.
- Async reset mid-stream while in TWO: assert `rst_n`=0 between clock edges → all outputs take their reset values immediately; after release, a new stream 7,8 is output as 7,8.
